pc_fetch_unit: RTL and testbench

//  Program counter and instruction-fetch stage of the CPU core. Holds the PC,

---
 rtl/pc_fetch_unit.sv | 96 +++++++++
 tb/tb_pc_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
// Fetches over req/ack and hands each word to decode over valid/ready.
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W    = 8,
    parameter int unsigned          DATA_W    = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [ADDR_W-1:0]    INC       = ADDR_W'(1),
    parameter logic [DATA_W-1:0]    HALT_INST = '1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_data,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst,
    input  logic              i_inst_ready,
    input  logic              i_br_take,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (i_run) state_d = FETCH;
            end
            FETCH: begin
                if (i_imem_ack) begin
                    inst_d  = i_imem_data;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && i_inst_ready) begin
                    valid_d = 1'b0;
                    // A halt word freezes the PC; branch inputs are irrelevant
                    if (inst_q == HALT_INST) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = i_br_take ? i_br_target : pc_q + INC;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_imem_req   = (state_q == FETCH);
    assign o_imem_addr  = pc_q;
    assign o_pc         = pc_q;
    assign o_inst_valid = valid_q;
    assign o_inst       = inst_q;
    assign o_halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized memory/decode agents with a queue scoreboard.
// The model walks the program by PC; a negedge monitor checks the DUT.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_run;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic        o_inst_valid;
    logic [15:0] o_inst;
    logic        i_inst_ready;
    logic        i_br_take;
    logic [7:0]  i_br_target;
    logic [7:0]  o_pc;
    logic        o_halted;

    pc_fetch_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_run        (i_run),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_data  (i_imem_data),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .i_inst_ready (i_inst_ready),
        .i_br_take    (i_br_take),
        .i_br_target  (i_br_target),
        .o_pc         (o_pc),
        .o_halted     (o_halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [15:0] mem [256];
    logic [7:0]  exp_addr [$];
    logic [15:0] exp_inst [$];
    logic [7:0]  model_pc;
    logic        model_halted;
    logic        halt_pend;
    int          n_acc;
    int          ack_wait;
    int          ack_lat_max;
    int          ready_pct;
    int          br_pct;
    logic        no_ack;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void fill_mem();
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w == 16'hFFFF) w = 16'h0000;
            mem[i] = w;
        end
    endfunction

    // Program-level model: an accepted word either halts or picks the next PC
    function automatic void accept(input logic take, input logic [7:0] tgt);
        n_acc++;
        if (mem[model_pc] == 16'hFFFF) begin
            halt_pend = 1'b1;
        end else begin
            model_pc = take ? tgt : model_pc + 8'd1;
            exp_addr.push_back(model_pc);
            exp_inst.push_back(mem[model_pc]);
        end
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        i_run        = 1'b0;
        i_imem_ack   = 1'b0;
        i_inst_ready = 1'b0;
        i_br_take    = 1'b0;
        exp_addr.delete();
        exp_inst.delete();
        model_halted = 1'b0;
        halt_pend    = 1'b0;
        n_acc        = 0;
        ack_wait     = 0;
        no_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        i_run    = 1'b1;
        model_pc = 8'h00;
        exp_addr.push_back(model_pc);
        exp_inst.push_back(mem[model_pc]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (halt_pend) begin
            model_halted = 1'b1;
            halt_pend    = 1'b0;
        end
        i_run        = 1'b0;
        i_imem_ack   = 1'b0;
        i_inst_ready = 1'b0;
        i_br_take    = 1'($urandom_range(0, 1));
        i_br_target  = 8'($urandom);
        i_imem_data  = 16'($urandom);
        if (o_imem_req && !no_ack) begin
            if (ack_wait == 0) begin
                i_imem_ack  = 1'b1;
                i_imem_data = mem[o_imem_addr];
                ack_wait    = $urandom_range(0, ack_lat_max);
            end else begin
                ack_wait--;
            end
        end
        if (o_inst_valid && ($urandom_range(0, 99) < ready_pct)) begin
            i_inst_ready = 1'b1;
            i_br_take    = ($urandom_range(0, 99) < br_pct);
            i_br_target  = ($urandom_range(0, 3) == 0) ? 8'hFF
                                                       : 8'($urandom);
            accept(i_br_take, i_br_target);
        end
    endtask

    logic        prev_req;
    logic        prev_valid;
    logic [7:0]  cur_addr;
    logic [15:0] cur_inst;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (o_imem_req && !prev_req) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_req actual=%0h required=none",
                             o_imem_addr);
                end else begin
                    cur_addr = exp_addr.pop_front();
                end
            end
            if (o_inst_valid && !prev_valid) begin
                checks++;
                if (exp_inst.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_valid actual=%0h required=none",
                             o_inst);
                end else begin
                    cur_inst = exp_inst.pop_front();
                end
            end
            if (o_imem_req) begin
                chk("fetch_addr", 32'(o_imem_addr), 32'(cur_addr));
                chk("pc_in_fetch", 32'(o_pc), 32'(cur_addr));
            end
            if (o_inst_valid) begin
                chk("inst_word", 32'(o_inst), 32'(cur_inst));
                chk("pc_in_hold", 32'(o_pc), 32'(cur_addr));
                chk("req_in_hold", 32'(o_imem_req), 32'd0);
            end
            chk("halted_flag", 32'(o_halted), 32'(model_halted));
            if (model_halted) begin
                chk("halt_req", 32'(o_imem_req), 32'd0);
                chk("halt_valid", 32'(o_inst_valid), 32'd0);
                chk("halt_pc", 32'(o_pc), 32'(cur_addr));
            end
            prev_req   = o_imem_req;
            prev_valid = o_inst_valid;
        end
    end

    initial begin
        rst_n        = 1'b0;
        i_run        = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_data  = 16'h0000;
        i_inst_ready = 1'b0;
        i_br_take    = 1'b0;
        i_br_target  = 8'h00;
        model_pc     = 8'h00;
        model_halted = 1'b0;
        halt_pend    = 1'b0;
        n_acc        = 0;
        ack_wait     = 0;
        ack_lat_max  = 0;
        ready_pct    = 100;
        br_pct       = 0;
        no_ack       = 1'b0;
        fill_mem();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(o_pc), 32'h00);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_addr", 32'(o_imem_addr), 32'h00);
        chk("rst_valid", 32'(o_inst_valid), 32'd0);
        chk("rst_inst", 32'(o_inst), 32'h0000);
        chk("rst_halted", 32'(o_halted), 32'd0);
        rst_n = 1'b1;

        // Sequential run 10,11,12 then a halt word at PC 3
        mem[0] = 16'd10;
        mem[1] = 16'd11;
        mem[2] = 16'd12;
        mem[3] = 16'hFFFF;
        start();
        repeat (24) step();
        chk("seq_accepts", 32'(n_acc), 32'd4);
        chk("seq_halted", 32'(o_halted), 32'd1);
        chk("seq_queue", 32'(exp_addr.size()), 32'd0);

        // Random latency, backpressure, branches and wraparound
        do_reset();
        fill_mem();
        ack_lat_max = 3;
        ready_pct   = 40;
        br_pct      = 30;
        start();
        repeat (1500) step();
        ready_pct = 0;
        repeat (10) step();
        chk("rand_addr_drained", 32'(exp_addr.size()), 32'd0);
        chk("rand_inst_drained", 32'(exp_inst.size()), 32'd0);
        chk("rand_progress", 32'(n_acc >= 100), 32'd1);

        // Reset in the middle of a fetch, then a stray ack
        do_reset();
        fill_mem();
        ack_lat_max = 0;
        ready_pct   = 100;
        br_pct      = 0;
        start();
        repeat (7) step();
        no_ack = 1'b1;
        repeat (4) step();
        chk("pre_rst_req", 32'(o_imem_req), 32'd1);
        chk("pre_rst_pc", 32'(o_pc), 32'(model_pc));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(o_imem_req), 32'd0);
        chk("mid_rst_pc", 32'(o_pc), 32'h00);
        chk("mid_rst_valid", 32'(o_inst_valid), 32'd0);
        exp_addr.delete();
        exp_inst.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        i_imem_ack  = 1'b1;
        i_imem_data = 16'h1234;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("late_ack_req", 32'(o_imem_req), 32'd0);
            chk("late_ack_valid", 32'(o_inst_valid), 32'd0);
            chk("late_ack_inst", 32'(o_inst), 32'h0000);
        end
        i_imem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
